rxd_wrapper: RTL and testbench
==============================

// Module: rxd_wrapper
// PURPOSE
//  UART receive side of the host serial link: deserialises 8N1 frames on SDI and
//  pairs consecutive bytes into one 16-bit word presented with a valid/ack handshake.
//  Counterpart of the two-byte transmit wrapper; first byte received = Data[15:8],
//  second = Data[7:0]. Sits between the board RS-232 pin and the command decoder.
// PARAMETERS
//  CLKS_PER_BIT  868  Clock cycles per bit (100 MHz / 115200); must be >= 4
//  TIMEOUT_BITS  20   Bit-times after byte 0 with no new start bit before the half word is dropped
// PORTS
//  Clock         in   1   System clock, all logic on rising edge
//  Reset         in   1   Asynchronous, active-low reset
//  SDI           in   1   Serial data in, idle high, asynchronous to Clock
//  Ack           in   1   Consumer has taken Data; sampled every cycle
//  Data          out  16  Assembled word; stable while Valid=1
//  Valid         out  1   Word available; held until Ack
//  Overrun       out  1   Sticky: a word completed while Valid=1 and Ack=0
//  FramingError  out  1   One-cycle pulse: stop bit sampled low
//  Busy          out  1   High whenever the bit FSM is not IDLE
// BEHAVIOUR
//  Reset (Reset=0): FSM=IDLE, byte index=0, Data=16'h0000, Valid=0, Overrun=0,
//   FramingError=0, Busy=0, synchroniser flops preset to 1 (line idle).
//  SDI passes a 2-flop synchroniser; all decisions use the synchronised value (s_sdi).
//  Bit FSM:
//   IDLE : s_sdi=0 -> START, bit counter cleared.
//   START: after CLKS_PER_BIT/2 cycles re-sample; 0 -> DATA; 1 -> IDLE (glitch, no error).
//   DATA : sample every CLKS_PER_BIT cycles, LSB first, 8 samples -> STOP.
//   STOP : sample after CLKS_PER_BIT; 1 -> byte good; 0 -> FramingError pulse, byte
//          discarded, byte index forced to 0. Either way -> IDLE on that cycle
//          (mid-stop), so back-to-back frames are received without loss.
//  Word assembly:
//   good byte, index 0 -> hold in Data_hi shadow, index=1, start timeout counter.
//   good byte, index 1 -> cycle after stop sample: Data={hi,byte}, Valid=1, index=0.
//   timeout: index=1 and no START entered within TIMEOUT_BITS*CLKS_PER_BIT cycles
//    -> index=0, shadow discarded, no flag. Counter stops when START entered.
//  Handshake:
//   Valid=1 and Ack=1 -> Valid=0 and Overrun=0 next cycle.
//   Word completes, Valid=1, Ack=0 -> Data NOT overwritten, new word dropped, Overrun=1.
//   Word completes in the same cycle as Ack=1 -> new word loaded, Valid stays 1, no Overrun.
//   Ack while Valid=0 is ignored.
//  Reset mid-frame: everything returns to reset values immediately; the partial frame
//   is lost. After release, a line already low is treated as a new start edge.
//  Latency: Valid rises 1 cycle after the mid-stop sample of the second byte.
// TESTING (bench uses CLKS_PER_BIT=8, TIMEOUT_BITS=4)
//  1 Send 0xF0 then 0xAA, Ack held 0 -> Data=16'hF0AA, Valid=1; Ack pulse -> Valid=0 next cycle.
//  2 0.25-bit low glitch on idle SDI -> no state change beyond START, Valid=0, FramingError=0.
//  3 Byte 0x55 with stop bit forced low -> 1-cycle FramingError; then 0x12,0x34 -> 16'h1234.
//  4 Send 0x01,0x02 with no Ack, then 0x03,0x04 -> Data stays 16'h0102, Overrun=1;
//    Ack -> Valid=0, Overrun=0.
//  5 Send 0xAB, idle 5 bit-times, send 0xCD,0xEF -> Data=16'hCDEF (0xAB dropped).
//  6 Assert Reset during bit 4 of byte 1 -> all outputs 0 at once; next 0x11,0x22 -> 16'h1122.

Source files
------------

// File: rtl/rxd_wrapper.sv
// UART 8N1 receiver that pairs consecutive bytes into 16-bit words.
// First byte lands in Data[15:8], second in Data[7:0]; valid/ack handshake out.
module rxd_wrapper #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_sdi,
    input  logic        i_ack,
    output logic [15:0] o_data,
    output logic        o_valid,
    output logic        o_overrun,
    output logic        o_framing_error,
    output logic        o_busy
);

    localparam int CW     = $clog2(CLKS_PER_BIT);
    localparam int TO_MAX = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW     = $clog2(TO_MAX + 1);

    localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TO_MAX - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]    r_sync;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_idx;
    logic [7:0]    r_hi;
    logic [TW-1:0] r_to_cnt;
    logic          r_fe;
    logic [15:0]   r_data;
    logic          r_valid;
    logic          r_overrun;

    logic w_s_sdi;
    logic w_stop_sample;
    logic w_good;
    logic w_word_done;
    logic w_timeout;

    assign w_s_sdi       = r_sync[1];
    assign w_stop_sample = (r_state == ST_STOP) && (r_cnt == LAST);
    assign w_good        = w_stop_sample && w_s_sdi;
    assign w_word_done   = w_good && r_idx;
    assign w_timeout     = r_idx && (r_state == ST_IDLE) && (r_to_cnt == TO_LAST);

    assign o_data          = r_data;
    assign o_valid         = r_valid;
    assign o_overrun       = r_overrun;
    assign o_framing_error = r_fe;
    assign o_busy          = (r_state != ST_IDLE);

    // Two-flop synchroniser, preset high so reset looks like an idle line
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_sdi};
        end
    end

    // Bit FSM: start detect, mid-bit sampling, early return to idle at mid-stop
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (!w_s_sdi) begin
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= w_s_sdi ? ST_IDLE : ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_s_sdi, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    // Byte pairing, half-word timeout and framing error pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx    <= 1'b0;
            r_hi     <= '0;
            r_to_cnt <= '0;
            r_fe     <= 1'b0;
        end else begin
            r_fe <= w_stop_sample && !w_s_sdi;
            if (w_stop_sample) begin
                if (w_s_sdi && !r_idx) begin
                    r_hi     <= r_shift;
                    r_idx    <= 1'b1;
                    r_to_cnt <= '0;
                end else begin
                    r_idx <= 1'b0;
                end
            end else if (r_state == ST_START) begin
                r_to_cnt <= '0;
            end else if (w_timeout) begin
                r_idx <= 1'b0;
            end else if (r_idx && (r_state == ST_IDLE)) begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end
        end
    end

    // Output word register with valid/ack handshake and sticky overrun
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_word_done) begin
            if (!r_valid || i_ack) begin
                r_data    <= {r_hi, r_shift};
                r_valid   <= 1'b1;
                r_overrun <= 1'b0;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && i_ack) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rxd_wrapper.sv
// Directed bench for rxd_wrapper with CLKS_PER_BIT=8, TIMEOUT_BITS=4.
// Each scenario task drives frames and checks outputs inline.
module tb_rxd_wrapper;

    logic        clk;
    logic        rst_n;
    logic        sdi;
    logic        ack;
    logic [15:0] data;
    logic        valid;
    logic        overrun;
    logic        fe;
    logic        busy;

    int checks;
    int failures;
    int fe_cycles;
    int busy_cycles;

    rxd_wrapper #(
        .CLKS_PER_BIT(8),
        .TIMEOUT_BITS(4)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_sdi          (sdi),
        .i_ack          (ack),
        .o_data         (data),
        .o_valid        (valid),
        .o_overrun      (overrun),
        .o_framing_error(fe),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles with framing error / busy high, sampled at negedge
    always @(negedge clk) begin
        if (fe) fe_cycles++;
        if (busy) busy_cycles++;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        sdi = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            sdi = b[i];
            repeat (8) @(negedge clk);
        end
        sdi = stop;
        repeat (8) @(negedge clk);
        sdi = 1'b1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sdi   = 1'b1;
        ack   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({data, valid, overrun, fe, busy} !== 20'h0) begin
            failures++;
            $display("FAIL reset_outputs got data=%h v=%b o=%b fe=%b b=%b want all 0",
                     data, valid, overrun, fe, busy);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        send_byte(8'hF0, 1'b1);
        send_byte(8'hAA, 1'b1);
        wait_valid(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL basic_valid_timeout got valid=%b want 1", valid);
        end
        checks++;
        if (data !== 16'hF0AA) begin
            failures++;
            $display("FAIL basic_data got %h want f0aa", data);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (valid !== 1'b1 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL basic_hold got valid=%b ovr=%b want 1 0", valid, overrun);
        end
        ack_pulse();
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_ack got valid=%b want 0", valid);
        end
    endtask

    task automatic test_glitch();
        int b0;
        int f0;
        b0  = busy_cycles;
        f0  = fe_cycles;
        sdi = 1'b0;
        repeat (2) @(negedge clk);
        sdi = 1'b1;
        repeat (24) @(negedge clk);
        checks++;
        if (busy_cycles - b0 < 1) begin
            failures++;
            $display("FAIL glitch_start got busy_cycles=%0d want >=1", busy_cycles - b0);
        end
        checks++;
        if (fe_cycles != f0 || valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_quiet got fe=%0d v=%b b=%b want 0 0 0",
                     fe_cycles - f0, valid, busy);
        end
    endtask

    task automatic test_framing();
        int f0;
        bit ok;
        f0 = fe_cycles;
        send_byte(8'h77, 1'b1);
        send_byte(8'h55, 1'b0);
        repeat (16) @(negedge clk);
        checks++;
        if (fe_cycles - f0 != 1) begin
            failures++;
            $display("FAIL framing_pulse got %0d cycles want 1", fe_cycles - f0);
        end
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL framing_novalid got valid=%b want 0", valid);
        end
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        wait_valid(ok);
        checks++;
        if (!ok || data !== 16'h1234) begin
            failures++;
            $display("FAIL framing_recover got v=%b data=%h want 1 1234", valid, data);
        end
        ack_pulse();
    endtask

    task automatic test_overrun();
        bit ok;
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        wait_valid(ok);
        checks++;
        if (!ok || data !== 16'h0102 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL ovr_first got v=%b data=%h o=%b want 1 0102 0",
                     valid, data, overrun);
        end
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (valid !== 1'b1 || data !== 16'h0102 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL ovr_second got v=%b data=%h o=%b want 1 0102 1",
                     valid, data, overrun);
        end
        ack_pulse();
        checks++;
        if (valid !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL ovr_ack got v=%b o=%b want 0 0", valid, overrun);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        send_byte(8'hAB, 1'b1);
        repeat (40) @(negedge clk);
        send_byte(8'hCD, 1'b1);
        send_byte(8'hEF, 1'b1);
        wait_valid(ok);
        checks++;
        if (!ok || data !== 16'hCDEF || overrun !== 1'b0) begin
            failures++;
            $display("FAIL timeout_drop got v=%b data=%h o=%b want 1 cdef 0",
                     valid, data, overrun);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [7:0] b;
        b = 8'h5A;
        send_byte(8'h99, 1'b1);
        sdi = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sdi = b[i];
            repeat (8) @(negedge clk);
        end
        sdi = b[4];
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || valid !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got b=%b v=%b want 1 1", busy, valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({data, valid, overrun, fe, busy} !== 20'h0) begin
            failures++;
            $display("FAIL rstmid_clear got data=%h v=%b o=%b fe=%b b=%b want all 0",
                     data, valid, overrun, fe, busy);
        end
        sdi = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (16) @(negedge clk);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        wait_valid(ok);
        checks++;
        if (!ok || data !== 16'h1122) begin
            failures++;
            $display("FAIL rstmid_after got v=%b data=%h want 1 1122", valid, data);
        end
        ack_pulse();
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        fe_cycles   = 0;
        busy_cycles = 0;
        rst_n       = 1'b0;
        sdi         = 1'b1;
        ack         = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_overrun();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
